// File: rtl/eth_pkg.sv
// Shared Ethernet constants, receive FSM state encoding and a byte-wide
// reflected CRC-32 step used by the GMII receive path.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
  localparam logic [31:0] ETH_CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC32_RESIDUE = 32'hDEBB20E3;
  localparam int          ETH_FCS_LENGTH    = 4;
  localparam int          ETH_PREAMBLE_MAX  = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  // One byte of LSB-first CRC-32; no final inversion, so a frame that
  // includes its own FCS leaves the register at ETH_CRC32_RESIDUE.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ ETH_CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide CRC-32 accumulator. Clear has priority over Valid and returns
// the register to the all-ones seed.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Clear,
  input  logic        Valid,
  input  logic [7:0]  Data,
  output logic [31:0] Crc
);

  // Accumulate one byte per valid cycle, reseed on Clear.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Crc <= ETH_CRC32_INIT;
    end else if (Clear) begin
      Crc <= ETH_CRC32_INIT;
    end else if (Valid) begin
      Crc <= crc32_byte(Crc, Data);
    end
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, delays the frame by the FCS
// length so the FCS is never emitted, and flags the last byte of a bad frame.
// Optional FCS checking: define GMII_RX_FRAMER_FCS_CHECK_EN.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   IDLE        | waiting for Gmii_rx_dv with a preamble byte
//   PREAMBLE    | counting 0x55 bytes (max 7), looking for the SFD
//   DATA        | frame body flows through delay line and hold register
//   DROP        | malformed start, discard until Gmii_rx_dv falls
module gmii_rx_framer
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int MAX_FRAME_LENGTH = 1518
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Gmii_rx_dv,
  input  logic        Gmii_rx_er,
  input  logic [7:0]  Gmii_rxd,
  output logic [7:0]  Output_data,
  output logic        Output_valid,
  output logic        Output_error,
  output logic [15:0] Status_good_frames,
  output logic [15:0] Status_bad_frames
);

  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_LENGTH);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME_LENGTH);
  localparam logic [15:0] FCS_LEN  = 16'(ETH_FCS_LENGTH);
  localparam logic [2:0]  PRE_MAX  = 3'(ETH_PREAMBLE_MAX);

  rx_state_e state, state_nxt;

  logic [2:0]                         pre_cnt;
  logic [15:0]                        len_cnt;
  logic                               err_seen;
  logic [ETH_FCS_LENGTH-1:0][7:0]     dly_line;
  logic [7:0]                         hold_data;
  logic                               hold_valid;
  logic                               fcs_bad;
  logic                               frame_bad;

  logic                               data_shift;
  logic                               frame_end;
  logic                               abort_bad;

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (Gmii_rx_dv)
          state_nxt = (Gmii_rxd == ETH_PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
        if (!Gmii_rx_dv)                        state_nxt = ST_IDLE;
        else if (Gmii_rx_er)                    state_nxt = ST_DROP;
        else if (Gmii_rxd == ETH_SFD_BYTE)      state_nxt = ST_DATA;
        else if (Gmii_rxd == ETH_PREAMBLE_BYTE && pre_cnt < PRE_MAX)
                                                state_nxt = ST_PREAMBLE;
        else                                    state_nxt = ST_DROP;
      end
      ST_DATA: if (!Gmii_rx_dv) state_nxt = ST_IDLE;
      ST_DROP: if (!Gmii_rx_dv) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    data_shift = 1'b0;
    frame_end  = 1'b0;
    abort_bad  = 1'b0;
    case (state)
      ST_PREAMBLE: abort_bad = !Gmii_rx_dv;
      ST_DATA: begin
        data_shift = Gmii_rx_dv;
        frame_end  = !Gmii_rx_dv;
      end
      ST_DROP:     abort_bad = !Gmii_rx_dv;
      default: ;
    endcase
  end

  // Preamble byte count; the byte that left IDLE counts as the first.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                                       pre_cnt <= 3'd0;
    else if (state == ST_IDLE)                        pre_cnt <= 3'd1;
    else if (state == ST_PREAMBLE && pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + 3'd1;
  end

  // Saturating frame length and sticky receive-error flag.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      len_cnt  <= 16'd0;
      err_seen <= 1'b0;
    end else if (state != ST_DATA) begin
      len_cnt  <= 16'd0;
      err_seen <= 1'b0;
    end else if (data_shift) begin
      if (len_cnt != 16'hFFFF) len_cnt <= len_cnt + 16'd1;
      err_seen <= err_seen | Gmii_rx_er;
    end
  end

`ifdef GMII_RX_FRAMER_FCS_CHECK_EN
  logic [31:0] crc;

  eth_crc32 u_crc32 (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Clear (state != ST_DATA),
    .Valid (data_shift),
    .Data  (Gmii_rxd),
    .Crc   (crc)
  );

  assign fcs_bad = (crc != ETH_CRC32_RESIDUE);
`else
  assign fcs_bad = 1'b0;
`endif

  assign frame_bad = err_seen || (len_cnt < MIN_LEN) || (len_cnt > MAX_LEN) || fcs_bad;

  // Delay line, hold register and output byte; the FCS is still in the
  // delay line when Gmii_rx_dv falls, so it is simply never released.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dly_line     <= '0;
      hold_data    <= 8'd0;
      hold_valid   <= 1'b0;
      Output_data  <= 8'd0;
      Output_valid <= 1'b0;
      Output_error <= 1'b0;
    end else begin
      Output_valid <= 1'b0;
      Output_error <= 1'b0;
      if (data_shift) begin
        dly_line   <= {dly_line[ETH_FCS_LENGTH-2:0], Gmii_rxd};
        hold_data  <= dly_line[ETH_FCS_LENGTH-1];
        hold_valid <= (len_cnt >= FCS_LEN);
        if (hold_valid) begin
          Output_data  <= hold_data;
          Output_valid <= 1'b1;
        end
      end else if (frame_end) begin
        hold_valid <= 1'b0;
        if (hold_valid) begin
          Output_data  <= hold_data;
          Output_valid <= 1'b1;
          Output_error <= frame_bad;
        end
      end
    end
  end

  // Frame statistics, updated on the edge that releases the final byte.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Status_good_frames <= 16'd0;
      Status_bad_frames  <= 16'd0;
    end else if (frame_end) begin
      if (hold_valid && !frame_bad) Status_good_frames <= Status_good_frames + 16'd1;
      else                          Status_bad_frames  <= Status_bad_frames + 16'd1;
    end else if (abort_bad) begin
      Status_bad_frames <= Status_bad_frames + 16'd1;
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: a table of frame scenarios plus
// hand-written sequences for DROP, back-to-back frames and mid-frame reset.
`timescale 1ns/1ps
module tb_gmii_rx_framer;
  import eth_pkg::*;

`ifdef GMII_RX_FRAMER_FCS_CHECK_EN
  localparam bit FCS_EN = 1'b1;
`else
  localparam bit FCS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  rxd = 8'd0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_error;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  gmii_rx_framer dut (
    .Clk                (clk),
    .Rst_n              (rst_n),
    .Gmii_rx_dv         (rx_dv),
    .Gmii_rx_er         (rx_er),
    .Gmii_rxd           (rxd),
    .Output_data        (out_data),
    .Output_valid       (out_valid),
    .Output_error       (out_error),
    .Status_good_frames (good_cnt),
    .Status_bad_frames  (bad_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output capture, sampled on the falling edge.
  logic [7:0] cap_data[$];
  logic       cap_err[$];
  int         cap_first_cyc = -1;
  always @(negedge clk) begin
    if (out_valid) begin
      if (cap_data.size() == 0) cap_first_cyc = cyc;
      cap_data.push_back(out_data);
      cap_err.push_back(out_error);
    end
  end

  task automatic clear_capture();
    cap_data.delete();
    cap_err.delete();
    cap_first_cyc = -1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  logic [7:0] tx_q[$];
  logic       tx_er[$];
  logic [7:0] exp_q[$];
  int         data_start;
  int         drv_cyc;

  // Preamble, start byte, then body_len bytes (FCS included when body_len >= 4).
  task automatic build(input int pre_len, input logic [7:0] sfd, input int body_len,
                       input int flip_idx, input int er_idx, input int seed);
    logic [7:0]  body[$];
    logic [31:0] crc;
    logic [7:0]  b;
    tx_q.delete(); tx_er.delete(); exp_q.delete();
    for (int i = 0; i < pre_len; i++) begin tx_q.push_back(8'h55); tx_er.push_back(1'b0); end
    tx_q.push_back(sfd); tx_er.push_back(1'b0);
    data_start = tx_q.size();
    crc = 32'hFFFFFFFF;
    if (body_len >= 4) begin
      for (int i = 0; i < body_len - 4; i++) begin
        b = 8'((i * 37 + seed) & 255);
        body.push_back(b);
        crc = crc_upd(crc, b);
      end
      crc = ~crc;
      for (int k = 0; k < 4; k++) body.push_back(crc[8*k +: 8]);
    end else begin
      for (int i = 0; i < body_len; i++) body.push_back(8'((i + seed) & 255));
    end
    if (flip_idx >= 0) body[flip_idx] = body[flip_idx] ^ 8'h01;
    for (int i = 0; i < body.size(); i++) begin
      tx_q.push_back(body[i]);
      tx_er.push_back(i == er_idx);
    end
    for (int i = 0; i < body_len - 4; i++) exp_q.push_back(body[i]);
  endtask

  // Drives the built stream, then exactly one idle cycle.
  task automatic drive_stream();
    for (int i = 0; i < tx_q.size(); i++) begin
      @(negedge clk);
      rx_dv = 1'b1; rx_er = tx_er[i]; rxd = tx_q[i];
      if (i == data_start) drv_cyc = cyc;
    end
    @(negedge clk);
    rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
  endtask

  typedef struct {
    int         pre_len;
    logic [7:0] sfd;
    int         body_len;
    int         flip_idx;
    int         er_idx;
    int         exp_out;
    logic       exp_err;
    int         d_good;
    int         d_bad;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  int exp_good = 0;
  int exp_bad  = 0;

  initial begin
    int mis, early, n0;
    logic [7:0] exp_a[$];

    vecs[0]  = '{7, 8'hD5, 64,   -1, -1, 60,   1'b0, 1, 0};
    vecs[1]  = '{7, 8'hD5, 64,    5, -1, 60,   FCS_EN, FCS_EN ? 0 : 1, FCS_EN ? 1 : 0};
    vecs[2]  = '{7, 8'hD5, 20,   -1, -1, 16,   1'b1, 0, 1};
    vecs[3]  = '{7, 8'hD5, 3,    -1, -1, 0,    1'b0, 0, 1};
    vecs[4]  = '{7, 8'hD5, 100,  -1, 10, 96,   1'b1, 0, 1};
    vecs[5]  = '{2, 8'hAB, 10,   -1, -1, 0,    1'b0, 0, 1};
    vecs[6]  = '{7, 8'hD5, 4,    -1, -1, 0,    1'b0, 0, 1};
    vecs[7]  = '{7, 8'hD5, 5,    -1, -1, 1,    1'b1, 0, 1};
    vecs[8]  = '{1, 8'hD5, 64,   -1, -1, 60,   1'b0, 1, 0};
    vecs[9]  = '{8, 8'hD5, 64,   -1, -1, 0,    1'b0, 0, 1};
    vecs[10] = '{7, 8'hD5, 63,   -1, -1, 59,   1'b1, 0, 1};
    vecs[11] = '{7, 8'hD5, 1518, -1, -1, 1514, 1'b0, 1, 0};
    vecs[12] = '{7, 8'hD5, 1519, -1, -1, 1515, 1'b1, 0, 1};
    vecs[13] = '{7, 8'h57, 64,   -1, -1, 0,    1'b0, 0, 1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_valid", out_valid, 0);
    check("reset_error", out_error, 0);
    check("reset_data", out_data, 0);
    check("reset_good", good_cnt, 0);
    check("reset_bad", bad_cnt, 0);
    check("reset_state", int'(dut.state), int'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      clear_capture();
      build(vecs[v].pre_len, vecs[v].sfd, vecs[v].body_len, vecs[v].flip_idx, vecs[v].er_idx, v * 11 + 3);
      drive_stream();
      repeat (8) @(negedge clk);
      exp_good += vecs[v].d_good;
      exp_bad  += vecs[v].d_bad;
      check($sformatf("v%0d_count", v), cap_data.size(), vecs[v].exp_out);
      if (vecs[v].exp_out > 0 && cap_data.size() == vecs[v].exp_out) begin
        mis = 0; early = 0;
        for (int k = 0; k < cap_data.size(); k++) begin
          if (cap_data[k] != exp_q[k]) mis++;
          if (k < cap_data.size() - 1 && cap_err[k]) early++;
        end
        check($sformatf("v%0d_data", v), mis, 0);
        check($sformatf("v%0d_early_err", v), early, 0);
        check($sformatf("v%0d_last_err", v), cap_err[cap_err.size() - 1], vecs[v].exp_err);
        // First body byte is driven half a cycle before its sampling edge and
        // shows up after the fifth edge that follows it.
        check($sformatf("v%0d_latency", v), cap_first_cyc - drv_cyc, 6);
      end
      check($sformatf("v%0d_good", v), good_cnt, exp_good);
      check($sformatf("v%0d_bad", v), bad_cnt, exp_bad);
    end

    // 55 55 AB: DROP until dv falls, then IDLE with one bad frame.
    clear_capture();
    build(2, 8'hAB, 10, -1, -1, 5);
    mis = 0;
    for (int i = 0; i < tx_q.size(); i++) begin
      @(negedge clk);
      if (i >= 3 && dut.state != ST_DROP) mis++;
      rx_dv = 1'b1; rx_er = 1'b0; rxd = tx_q[i];
    end
    @(negedge clk);
    if (dut.state != ST_DROP) mis++;
    rx_dv = 1'b0; rxd = 8'h00;
    @(negedge clk);
    check("drop_state_hold", mis, 0);
    check("drop_exit_idle", int'(dut.state), int'(ST_IDLE));
    repeat (4) @(negedge clk);
    exp_bad++;
    check("drop_count", cap_data.size(), 0);
    check("drop_bad", bad_cnt, exp_bad);

    // Back-to-back valid frames separated by one idle cycle.
    clear_capture();
    build(7, 8'hD5, 64, -1, -1, 17);
    exp_a = exp_q;
    drive_stream();
    build(7, 8'hD5, 70, -1, -1, 91);
    for (int k = 0; k < exp_q.size(); k++) exp_a.push_back(exp_q[k]);
    drive_stream();
    repeat (8) @(negedge clk);
    exp_good += 2;
    check("b2b_count", cap_data.size(), 126);
    if (cap_data.size() == 126) begin
      mis = 0; early = 0;
      for (int k = 0; k < 126; k++) begin
        if (cap_data[k] != exp_a[k]) mis++;
        if (cap_err[k]) early++;
      end
      check("b2b_data", mis, 0);
      check("b2b_err_flags", early, 0);
    end
    check("b2b_good", good_cnt, exp_good);
    check("b2b_bad", bad_cnt, exp_bad);

    // Reset asserted mid-frame, released with dv still high.
    clear_capture();
    build(7, 8'hD5, 64, -1, -1, 21);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rx_dv = 1'b1; rx_er = 1'b0; rxd = tx_q[i];
    end
    @(negedge clk);
    rxd = tx_q[30];
    #2;
    n0 = cap_data.size();
    rst_n = 1'b0;
    check("rst_pre_count", n0, 17);
    for (int i = 31; i < 34; i++) begin
      @(negedge clk);
      rxd = tx_q[i];
    end
    check("rst_valid_low", out_valid, 0);
    check("rst_data_zero", out_data, 0);
    check("rst_good_zero", good_cnt, 0);
    check("rst_bad_zero", bad_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rxd = tx_q[34];
    for (int i = 35; i < tx_q.size(); i++) begin
      @(negedge clk);
      rxd = tx_q[i];
    end
    @(negedge clk);
    check("rst_after_drop", int'(dut.state), int'(ST_DROP));
    rx_dv = 1'b0; rxd = 8'h00;
    repeat (8) @(negedge clk);
    check("rst_no_final_byte", cap_data.size(), n0);
    check("rst_post_good", good_cnt, 0);
    check("rst_post_bad", bad_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gmii_rx_framer.md
GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

Interface
REQ-001 SHALL have parameter MIN_FRAME_LENGTH, default 64: minimum legal frame bytes after SFD, FCS included.
REQ-002 SHALL have parameter MAX_FRAME_LENGTH, default 1518: maximum legal frame bytes after SFD, FCS included.
REQ-003 SHALL have port Clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port Rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port Gmii_rx_dv, input, 1 bit: receive data valid.
REQ-006 SHALL have port Gmii_rx_er, input, 1 bit: receive error.
REQ-007 SHALL have port Gmii_rxd, input, 8 bits: receive byte.
REQ-008 SHALL have port Output_data, output, 8 bits: frame byte, preamble/SFD/FCS stripped; feeds gmii_buffer Input_data.
REQ-009 SHALL have port Output_valid, output, 1 bit: Output_data valid; no backpressure.
REQ-010 SHALL have port Output_error, output, 1 bit: asserted only with the final byte of a bad frame.
REQ-011 SHALL have port Status_good_frames, output, 16 bits: count of frames ended without error; wraps.
REQ-012 SHALL have port Status_bad_frames, output, 16 bits: count of frames ended with error or dropped; wraps.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, DATA and DROP.
REQ-014 SHALL move IDLE->PREAMBLE on Gmii_rx_dv=1 with 8'h55.
REQ-015 SHALL move IDLE->DROP on Gmii_rx_dv=1 with any other byte.
REQ-016 SHALL stay in PREAMBLE on 8'h55 for up to 7 total preamble bytes.
REQ-017 SHALL move PREAMBLE->DATA on 8'hD5 (SFD).
REQ-018 SHALL move PREAMBLE->DROP on an 8th 8'h55, on any other byte, or on Gmii_rx_er.
REQ-019 SHALL move PREAMBLE->IDLE on Gmii_rx_dv=0, with no output and bad count incremented.
REQ-020 SHALL, in DATA, push each byte into a 4-byte delay line; the byte shifted out loads a 1-entry hold register.
REQ-021 SHALL release a held byte with Output_valid=1 and Output_error=0 when the next byte displaces it.
REQ-022 SHALL, on Gmii_rx_dv falling in DATA, release the held byte in the next cycle with Output_valid=1 and Output_error=bad, discard the 4 FCS bytes and return to IDLE.
REQ-023 SHALL set bad = any Gmii_rx_er during the frame OR length<MIN_FRAME_LENGTH OR length>MAX_FRAME_LENGTH OR FCS mismatch (when compiled in).
REQ-024 SHALL, for frames of 4 or fewer bytes after SFD, produce no output and increment bad count.
REQ-025 SHALL use a 16-bit length counter that saturates at 16'hFFFF.
REQ-026 SHALL, in DROP, ignore bytes until Gmii_rx_dv=0, then go to IDLE and increment bad count once.
REQ-027 SHALL place output bytes at most one per cycle and in order; latency from Gmii_rxd to Output_data is 5 cycles.
REQ-028 SHALL update counters in the cycle the final byte is output; Gmii_rx_dv re-asserting in that same cycle starts a new frame normally.

Reset
REQ-029 SHALL, while Rst_n=0, set state to IDLE, Output_valid=0, Output_error=0, Output_data=0, counters=0, and clear the delay line, hold register and CRC.
REQ-030 SHALL, when Rst_n is asserted mid-frame, discard the partial frame without emitting a final byte; after release it waits in IDLE, so bytes with Gmii_rx_dv already high go to DROP.

Configuration
REQ-031 SHALL, with macro GMII_RX_FRAMER_FCS_CHECK_EN defined, run CRC-32 (reflected 32'hEDB88320, init 32'hFFFFFFFF) over all bytes after SFD including FCS, and flag mismatch unless the register equals residue 32'hDEBB20E3.
REQ-032 SHALL, with GMII_RX_FRAMER_FCS_CHECK_EN undefined, instantiate no CRC logic and treat FCS as never mismatched; FCS is still stripped.

Structure
REQ-033 SHALL take ETH_PREAMBLE_BYTE, ETH_SFD_BYTE, ETH_CRC32_POLY, ETH_CRC32_RESIDUE, the ETH_FCS_LENGTH=4 constant and the state enum from shared package eth_pkg.
REQ-034 SHALL place the byte-wide CRC-32 update in sub-module eth_crc32 (ports: Clk, Rst_n, Clear, Valid, Data, Crc).

Verification
REQ-035 SHALL verify: 7x55, D5, 60 data bytes, valid FCS -> 60 bytes out, last Output_error=0, good=1.
REQ-036 SHALL verify: same frame with one data bit flipped -> 60 bytes out, last Output_error=1, bad=1 (compiled-in); Output_error=0 with macro undefined.
REQ-037 SHALL verify: preamble 55 55 AB -> no output, bad=1, state DROP until Gmii_rx_dv falls.
REQ-038 SHALL verify: 20-byte frame with valid FCS -> 16 bytes out, last Output_error=1 (runt); a 3-byte frame gives no output and bad=1.
REQ-039 SHALL verify: Gmii_rx_er pulse on data byte 10 of a 100-byte frame -> 96 bytes out, only the final byte flagged.
REQ-040 SHALL verify: back-to-back frames with one idle cycle, then Rst_n low mid-frame -> both frames correct, partial frame produces no final byte, counters zeroed.
